serial_alu_gen: RTL and testbench
=================================

# serial_alu_gen

Parametrised bit-serial ALU with an internal register file. It processes one NSHIFT-bit digit per cycle, least significant digit first, over 1, 2 or 4 chained registers (8/16/32-bit at defaults). Operations are issued through a start/busy/done handshake that supports back-to-back issue. It sits between the CPU sequencer, which issues operations, and the memory/immediate path, which streams data_in and consumes data_out.

## Interface
Parameters:
- LOG2_NR, 3: log2 of register count.
- REG_BITS, 8: bits per register; must be a multiple of NSHIFT.
- NSHIFT, 2: digit width in bits; legal values are 1, 2, 4.
- MAX_WORDS, 4: maximum chained registers; legal values are 1, 2, 4.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  issue request; accepted when busy=0 or done=1.
- op  in  3  operation: 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 MOV.
- words_sel  in  2  number of chained registers: 0 → 1, 1 → 2, 2 → 4; 3 is treated as 4. Must not exceed MAX_WORDS.
- reg1  in  LOG2_NR  destination and first operand (group base).
- reg2  in  LOG2_NR  second operand (group base).
- ext_arg2  in  1  take arg2 from data_in instead of reg2.
- write_en  in  1  write the result to reg1 (0 = compare/test).
- data_in  in  NSHIFT  external arg2 digit; sampled in each busy cycle.
- data_out  out  NSHIFT  result digit of the current busy cycle (combinational).
- busy  out  1  a digit is processed this cycle.
- done  out  1  current cycle processes the last digit.
- digit_idx  out  clog2(MAX_WORDS*REG_BITS/NSHIFT)  index of the digit being processed.
- flag_c, flag_v, flag_s, flag_z  out  1  status flags.

## Operation
- Accept: start=1 at a rising edge with (busy=0 or done=1). That edge latches op, words_sel, reg1, reg2, ext_arg2 and write_en, and loads the counter with 0. All control inputs are ignored while busy=1 and done=0.
- Length: N = (REG_BITS/NSHIFT) << words_sel digits.
- Digit k: word w = k / (REG_BITS/NSHIFT); position p = k mod (REG_BITS/NSHIFT).
  - Register index = base with its low words_sel bits replaced by w. Word 0 is the least significant.
  - arg1 = reg1-group digit; arg2 = data_in when ext_arg2=1, otherwise the reg2-group digit.
- Carry-in for digit 0:
  - ADD: 0. SUB: 1 (arg2 inverted).
  - ADC: flag_c. SBC: flag_c with arg2 inverted.
- Carry-in for later digits is the carry-out of the previous digit.
- Result per digit: sum for ops 0-3; arg1&arg2, arg1|arg2, arg1^arg2 for ops 4-6; arg2 for MOV.
- Writeback: when write_en=1, the result digit is written to the reg1-group digit at the same edge.
  - Reads in a cycle return pre-write values, so reg1 == reg2 aliasing is legal.
- Flags are updated at the done edge:
  - Ops 0-3:
    - C = final carry-out. For SUB/SBC, 1 means no borrow.
    - V = carry into the MSB XOR carry out of the MSB.
  - Ops 0-6:
    - S = MSB of the final digit.
    - Z = all N result digits zero. Accumulate Z per digit; digit 0 ignores prior Z.
  - Logic ops leave C and V unchanged. MOV leaves all flags unchanged.
- Register file: 2^LOG2_NR × REG_BITS flops. It is reachable only through operations: load with MOV + ext_arg2; read out via data_out using MOV with write_en=0, ext_arg2=0, reg2=source.
- Reset, including mid-operation:
  - busy=0, done=0, digit_idx=0.
  - All flags 0, all registers 0.
  - The in-flight operation is abandoned with no partial flag update.

## Timing
- Start accepted at edge T → busy=1 in cycles T+1 … T+N; digit_idx = k in cycle T+1+k.
- done=1 only in cycle T+N.
- data_out is valid combinationally in each busy cycle. data_in must be stable in the same cycle.
- Flags reflect the operation from cycle T+N+1 onward. An ADC/SBC issued back-to-back sees the updated flag_c.
- Back-to-back: start=1 during the done cycle keeps busy=1 with no bubble; the next op's digit 0 is in cycle T+N+1.
- Without a new start, busy=0 from T+N+1. data_out is don't-care when idle but must be stable (no X).
- Latency from start to first result digit: 1 cycle. Throughput: one NSHIFT-bit digit per cycle.

## Test plan
- Defaults, 8-bit add with overflow:
  - MOV ext r0←0x7F; MOV ext r1←0x01; ADD r0,r1.
  - Required: 4 busy cycles, done in the 4th; r0=0x80; C=0, V=1, S=1, Z=0.
- 16-bit SUB, words_sel=1:
  - Set r0:r1=0x0100 (r0 = low), r2:r3=0x0001; SUB r0,r2.
  - Required: 8 busy cycles, r0=0xFF, r1=0x00, C=1, V=0, Z=0.
- Compare via SBC, write_en=0:
  - flag_c=0, r4=0x05, ext data=0x05.
  - Required: r4 unchanged, Z=0, C=0.
  - With flag_c=1: Z=1, C=1.
- Back-to-back: ADD then ADC issued in the done cycle of the first.
  - Required: busy never drops.
  - Chained 0xFF+0x01 then 0x00+0x00 gives 0x01 in the second destination.
- Reset mid-op: assert reset at digit 2 of a 32-bit op.
  - Required: busy, done and flags go to 0 asynchronously; registers read back 0.
- NSHIFT=4, REG_BITS=8, words_sel=2:
  - XOR 0x12345678 ^ 0xFFFFFFFF.
  - Required: 8 busy cycles, result 0xEDCBA987, S=1, C and V unchanged.

Source files
------------

// File: rtl/serial_alu_gen.sv
// Bit-serial ALU with a small internal register file.
// One NSHIFT-bit digit per cycle, LSD first, over 1/2/4 chained registers.
module serial_alu_gen #(
  parameter int LOG2_NR   = 3,
  parameter int REG_BITS  = 8,
  parameter int NSHIFT    = 2,
  parameter int MAX_WORDS = 4,
  localparam int ND = MAX_WORDS * REG_BITS / NSHIFT,
  localparam int CW = (ND > 1) ? $clog2(ND) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [1:0]         words_sel,
  input  logic [LOG2_NR-1:0] reg1,
  input  logic [LOG2_NR-1:0] reg2,
  input  logic               ext_arg2,
  input  logic               write_en,
  input  logic [NSHIFT-1:0]  data_in,
  output logic [NSHIFT-1:0]  data_out,
  output logic               busy,
  output logic               done,
  output logic [CW-1:0]      digit_idx,
  output logic               flag_c,
  output logic               flag_v,
  output logic               flag_s,
  output logic               flag_z
);

  localparam int NR  = 1 << LOG2_NR;
  localparam int DPR = REG_BITS / NSHIFT;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_ADC, OP_SBC,
    OP_AND, OP_OR, OP_XOR, OP_MOV
  } op_e;

  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic [1:0]         ws_q, ws_d;
  logic [LOG2_NR-1:0] r1_q, r1_d;
  logic [LOG2_NR-1:0] r2_q, r2_d;
  logic               ext_q, ext_d;
  logic               we_q, we_d;
  logic               carry_q, carry_d;
  logic               z_q, z_d;
  logic               fc_q, fc_d;
  logic               fv_q, fv_d;
  logic               fs_q, fs_d;
  logic               fz_q, fz_d;
  logic [REG_BITS-1:0] regs_q [NR];
  logic [REG_BITS-1:0] regs_d [NR];

  logic [LOG2_NR-1:0] wmask, word, i1, i2;
  int                 off;
  logic [NSHIFT-1:0]  a, b, bx, res;
  logic [NSHIFT:0]    sum;
  logic               first, cin, c_msb, z_acc;
  logic [CW-1:0]      last;
  logic               accept;

  // Digit datapath: operand fetch, add/logic, carry and zero tracking
  always_comb begin
    wmask = LOG2_NR'((1 << ws_q) - 1);
    word  = LOG2_NR'(int'(cnt_q) / DPR);
    i1    = (r1_q & ~wmask) | (word & wmask);
    i2    = (r2_q & ~wmask) | (word & wmask);
    off   = (int'(cnt_q) % DPR) * NSHIFT;
    a     = regs_q[i1][off +: NSHIFT];
    b     = ext_q ? data_in : regs_q[i2][off +: NSHIFT];
    bx    = (op_q[0] && !op_q[2]) ? ~b : b;
    first = (cnt_q == '0);
    case (op_q)
      OP_ADD:  cin = first ? 1'b0 : carry_q;
      OP_SUB:  cin = first ? 1'b1 : carry_q;
      default: cin = first ? fc_q : carry_q;
    endcase
    sum   = {1'b0, a} + {1'b0, bx} + {{NSHIFT{1'b0}}, cin};
    c_msb = a[NSHIFT-1] ^ bx[NSHIFT-1] ^ sum[NSHIFT-1];
    unique case (op_q)
      OP_ADD, OP_SUB,
      OP_ADC, OP_SBC: res = sum[NSHIFT-1:0];
      OP_AND:         res = a & b;
      OP_OR:          res = a | b;
      OP_XOR:         res = a ^ b;
      OP_MOV:         res = b;
    endcase
    z_acc = (first | z_q) & (res == '0);
    last  = CW'((DPR << ws_q) - 1);
  end

  assign done      = busy_q && (cnt_q == last);
  assign busy      = busy_q;
  assign digit_idx = cnt_q;
  assign data_out  = busy_q ? res : '0;
  assign flag_c    = fc_q;
  assign flag_v    = fv_q;
  assign flag_s    = fs_q;
  assign flag_z    = fz_q;
  assign accept    = start && (!busy_q || done);

  // Issue handshake, digit counter, flags and register writeback
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ws_d    = ws_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    ext_d   = ext_q;
    we_d    = we_q;
    carry_d = carry_q;
    z_d     = z_q;
    fc_d    = fc_q;
    fv_d    = fv_q;
    fs_d    = fs_q;
    fz_d    = fz_q;
    regs_d  = regs_q;
    if (busy_q) begin
      carry_d = sum[NSHIFT];
      z_d     = z_acc;
      if (we_q) regs_d[i1][off +: NSHIFT] = res;
    end
    if (done) begin
      if (!op_q[2]) begin
        fc_d = sum[NSHIFT];
        fv_d = c_msb ^ sum[NSHIFT];
      end
      if (op_q != OP_MOV) begin
        fs_d = res[NSHIFT-1];
        fz_d = z_acc;
      end
    end
    if (accept) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      op_d   = op_e'(op);
      ws_d   = (words_sel == 2'd3) ? 2'd2 : words_sel;
      r1_d   = reg1;
      r2_d   = reg2;
      ext_d  = ext_arg2;
      we_d   = write_en;
    end else if (done) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q) begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // State registers; reset abandons any in-flight operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      ws_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      ext_q   <= 1'b0;
      we_q    <= 1'b0;
      carry_q <= 1'b0;
      z_q     <= 1'b0;
      fc_q    <= 1'b0;
      fv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fz_q    <= 1'b0;
      for (int i = 0; i < NR; i++) regs_q[i] <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ws_q    <= ws_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      ext_q   <= ext_d;
      we_q    <= we_d;
      carry_q <= carry_d;
      z_q     <= z_d;
      fc_q    <= fc_d;
      fv_q    <= fv_d;
      fs_q    <= fs_d;
      fz_q    <= fz_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_serial_alu_gen.sv
// Directed bench for serial_alu_gen: NSHIFT=2 and NSHIFT=4 instances.
// Expected values are hand-computed constants.
module tb_serial_alu_gen;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, ADC = 3'd2, SBC = 3'd3;
  localparam logic [2:0] XOR = 3'd6, MOV = 3'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic [2:0] op;
  logic [1:0] ws;
  logic [2:0] r1, r2;
  logic       ext, we;
  logic [1:0] din_a, dout_a;
  logic [3:0] din_b, dout_b;
  logic       busy_a, done_a, busy_b, done_b;
  logic [3:0] di_a;
  logic [2:0] di_b;
  logic       fc_a, fv_a, fs_a, fz_a;
  logic       fc_b, fv_b, fs_b, fz_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_alu_gen #(
    .LOG2_NR(3), .REG_BITS(8), .NSHIFT(2), .MAX_WORDS(4)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .op(op),
    .words_sel(ws), .reg1(r1), .reg2(r2), .ext_arg2(ext),
    .write_en(we), .data_in(din_a), .data_out(dout_a),
    .busy(busy_a), .done(done_a), .digit_idx(di_a),
    .flag_c(fc_a), .flag_v(fv_a), .flag_s(fs_a), .flag_z(fz_a)
  );

  serial_alu_gen #(
    .LOG2_NR(3), .REG_BITS(8), .NSHIFT(4), .MAX_WORDS(4)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .op(op),
    .words_sel(ws), .reg1(r1), .reg2(r2), .ext_arg2(ext),
    .write_en(we), .data_in(din_b), .data_out(dout_b),
    .busy(busy_b), .done(done_b), .digit_idx(di_b),
    .flag_c(fc_b), .flag_v(fv_b), .flag_s(fs_b), .flag_z(fz_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags(input int which);
    if (which == 0) return {28'd0, fc_a, fv_a, fs_a, fz_a};
    return {28'd0, fc_b, fv_b, fs_b, fz_b};
  endfunction

  // Issue one op on instance 'which', stream x as ext data, collect data_out
  task automatic run_op(input int which, input logic [2:0] o,
                        input logic [1:0] w, input logic [2:0] a,
                        input logic [2:0] b, input logic e,
                        input logic wr, input logic [31:0] x,
                        output logic [31:0] res, output int ncyc,
                        output int done_at, output int ndone);
    int ns;
    logic [31:0] dv;
    logic bsy, dn;
    int idx;
    ns = (which == 0) ? 2 : 4;
    @(negedge clk);
    op = o; ws = w; r1 = a; r2 = b; ext = e; we = wr;
    if (which == 0) start_a = 1'b1;
    else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    res = '0; ncyc = 0; done_at = -1; ndone = 0;
    bsy = (which == 0) ? busy_a : busy_b;
    while (bsy && ncyc < 40) begin
      din_a = 2'(x >> (ncyc * 2));
      din_b = 4'(x >> (ncyc * 4));
      #1;
      dv  = (which == 0) ? {30'd0, dout_a} : {28'd0, dout_b};
      idx = (which == 0) ? int'(di_a) : int'(di_b);
      dn  = (which == 0) ? done_a : done_b;
      chk($sformatf("idx%0d", ncyc), idx, ncyc);
      res = res | (dv << (ncyc * ns));
      if (dn) begin
        ndone++;
        done_at = ncyc;
      end
      ncyc++;
      @(negedge clk);
      bsy = (which == 0) ? busy_a : busy_b;
    end
    if (ncyc >= 40) chk("busy_timeout", ncyc, 0);
  endtask

  task automatic rd(input int which, input logic [1:0] w,
                    input logic [2:0] r, output logic [31:0] res);
    int n, da, nd;
    run_op(which, MOV, w, r, r, 1'b0, 1'b0, 32'd0, res, n, da, nd);
  endtask

  initial begin
    logic [31:0] res;
    int n, da, nd;
    logic ok;
    reset = 1'b1;
    start_a = 0; start_b = 0; op = 0; ws = 0; r1 = 0; r2 = 0;
    ext = 0; we = 0; din_a = 0; din_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_idx", di_a, 0);
    chk("rst_flags", flags(0), 0);
    reset = 1'b0;

    // 8-bit add with signed overflow
    run_op(0, MOV, 0, 0, 0, 1, 1, 32'h7F, res, n, da, nd);
    chk("mov_cyc", n, 4);
    run_op(0, MOV, 0, 1, 1, 1, 1, 32'h01, res, n, da, nd);
    chk("mov_flags", flags(0), 0);
    run_op(0, ADD, 0, 0, 1, 0, 1, 32'h0, res, n, da, nd);
    chk("add_cyc", n, 4);
    chk("add_done_at", da, 3);
    chk("add_ndone", nd, 1);
    chk("add_res", res, 32'h80);
    chk("add_cvsz", flags(0), 4'b0110);
    rd(0, 0, 0, res);
    chk("add_r0", res, 32'h80);

    // 16-bit subtract across r0:r1 and r2:r3
    run_op(0, MOV, 1, 0, 0, 1, 1, 32'h0100, res, n, da, nd);
    run_op(0, MOV, 1, 2, 2, 1, 1, 32'h0001, res, n, da, nd);
    run_op(0, SUB, 1, 0, 2, 0, 1, 32'h0, res, n, da, nd);
    chk("sub_cyc", n, 8);
    chk("sub_done_at", da, 7);
    chk("sub_res", res, 32'h00FF);
    chk("sub_cvsz", flags(0), 4'b1000);
    rd(0, 0, 0, res);
    chk("sub_r0", res, 32'hFF);
    rd(0, 0, 1, res);
    chk("sub_r1", res, 32'h00);

    // Compare via SBC with no writeback
    run_op(0, ADD, 0, 5, 5, 0, 0, 32'h0, res, n, da, nd);
    chk("clr_c", flags(0), 4'b0001);
    run_op(0, MOV, 0, 4, 4, 1, 1, 32'h05, res, n, da, nd);
    run_op(0, SBC, 0, 4, 0, 1, 0, 32'h05, res, n, da, nd);
    chk("cmp0_res", res, 32'hFF);
    chk("cmp0_cvsz", flags(0), 4'b0010);
    rd(0, 0, 4, res);
    chk("cmp0_r4", res, 32'h05);
    run_op(0, SUB, 0, 5, 5, 0, 0, 32'h0, res, n, da, nd);
    chk("set_c", flags(0), 4'b1001);
    run_op(0, SBC, 0, 4, 0, 1, 0, 32'h05, res, n, da, nd);
    chk("cmp1_res", res, 32'h00);
    chk("cmp1_cvsz", flags(0), 4'b1001);

    // Back-to-back ADD then ADC issued in the done cycle
    run_op(0, MOV, 0, 6, 6, 1, 1, 32'hFF, res, n, da, nd);
    run_op(0, MOV, 0, 7, 7, 1, 1, 32'h01, res, n, da, nd);
    @(negedge clk);
    op = ADD; ws = 0; r1 = 6; r2 = 7; ext = 0; we = 1; start_a = 1;
    @(negedge clk);
    start_a = 0;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      ok &= busy_a;
      if (k == 3) begin
        chk("b2b_done1", done_a, 1);
        op = ADC; r1 = 5; r2 = 5; start_a = 1;
      end
      @(negedge clk);
      start_a = 0;
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      ok &= busy_a;
      if (k == 3) chk("b2b_done2", done_a, 1);
      @(negedge clk);
    end
    chk("b2b_no_bubble", ok, 1);
    chk("b2b_idle", busy_a, 0);
    chk("b2b_flags", flags(0), 0);
    rd(0, 0, 5, res);
    chk("b2b_r5", res, 32'h01);
    rd(0, 0, 6, res);
    chk("b2b_r6", res, 32'h00);

    // Asynchronous reset at digit 2 of a 32-bit op
    run_op(0, SUB, 0, 0, 0, 0, 0, 32'h0, res, n, da, nd);
    chk("pre_rst_flags", flags(0), 4'b1001);
    @(negedge clk);
    op = ADD; ws = 2; r1 = 0; r2 = 4; ext = 0; we = 1; start_a = 1;
    @(negedge clk);
    start_a = 0;
    for (int k = 0; k < 20 && di_a != 4'd2; k++) @(negedge clk);
    chk("rst_at_d2", di_a, 2);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_idx", di_a, 0);
    chk("mid_rst_flags", flags(0), 0);
    @(negedge clk);
    reset = 1'b0;
    rd(0, 2, 4, res);
    chk("rst_r4_7", res, 0);
    rd(0, 2, 0, res);
    chk("rst_r0_3", res, 0);

    // NSHIFT=4 instance: 32-bit XOR keeps C and V
    run_op(1, SUB, 0, 0, 0, 0, 0, 32'h0, res, n, da, nd);
    chk("b_set_c", flags(1), 4'b1001);
    run_op(1, MOV, 2, 0, 0, 1, 1, 32'h12345678, res, n, da, nd);
    run_op(1, MOV, 2, 4, 4, 1, 1, 32'hFFFFFFFF, res, n, da, nd);
    run_op(1, XOR, 2, 0, 4, 0, 1, 32'h0, res, n, da, nd);
    chk("xor_cyc", n, 8);
    chk("xor_done_at", da, 7);
    chk("xor_res", res, 32'hEDCBA987);
    chk("xor_cvsz", flags(1), 4'b1010);
    rd(1, 2, 0, res);
    chk("xor_r0_3", res, 32'hEDCBA987);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
